// File: rtl/multiplier_iterative_param.sv
// Iterative shift-add multiplier: retires BITS_PER_CYCLE multiplier bits per clock,
// works on operand magnitudes and applies the sign once at completion.
module multiplier_iterative_param #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_in,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [2*WIDTH-1:0]   r
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam int PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : g_bad_bpc
        $error("BITS_PER_CYCLE must be 1, 2 or 4");
    end
    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of BITS_PER_CYCLE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Most-negative input maps to 2^(WIDTH-1), which still fits as an unsigned value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        if (is_signed && (sv < 0)) begin
            return -v;
        end
        return v;
    endfunction

    function automatic logic [PW-1:0] digit_product(input logic [PW-1:0]             mcand,
                                                    input logic [BITS_PER_CYCLE-1:0] digit);
        logic [PW-1:0] sum;
        sum = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (digit[j]) begin
                sum = sum + (mcand << j);
            end
        end
        return sum;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag,
                                                 input logic          neg);
        return neg ? -mag : mag;
    endfunction

    state_e            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplr_q,  mplr_d;
    logic [PW-1:0]     acc_q,   acc_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              neg_q,   neg_d;
    logic [PW-1:0]     r_q,     r_d;

    logic              accept;
    logic [PW-1:0]     acc_sum;
    logic [CNT_W-1:0]  cnt_inc;

    always_comb begin
        ready_in  = 1'b0;
        valid_out = 1'b0;
        case (state_q)
            IDLE:    ready_in = 1'b1;
            DONE: begin
                valid_out = 1'b1;
                ready_in  = ready_out;
            end
            default: ready_in = 1'b0;
        endcase
    end

    assign accept  = valid_in && ready_in;
    assign acc_sum = acc_q + digit_product(mcand_q, mplr_q[BITS_PER_CYCLE-1:0]);
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign r       = r_q;

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        r_d     = r_q;

        case (state_q)
            RUN: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << BITS_PER_CYCLE;
                mplr_d  = mplr_q >> BITS_PER_CYCLE;
                cnt_d   = cnt_inc;
                if (cnt_inc == STEPS_C) begin
                    r_d     = apply_sign(acc_sum, neg_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_out) begin
                    state_d = IDLE;
                end
            end
            IDLE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new operation may be taken in IDLE or on the DONE hand-off edge (no bubble).
        if (accept) begin
            mcand_d = {{WIDTH{1'b0}}, magnitude(a, signed_in)};
            mplr_d  = magnitude(b, signed_in);
            neg_d   = signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            r_q     <= r_d;
        end
    end

endmodule

// File: tb/tb_multiplier_iterative_param.sv
// Scoreboard bench for multiplier_iterative_param: a 32x32 BPC=1 instance and a 16x16 BPC=4 instance.
module tb_multiplier_iterative_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        v32, rdy_in32, s32, vo32, ro32;
    logic [31:0] a32, b32;
    logic [63:0] r32;

    logic        v16, rdy_in16, s16, vo16, ro16;
    logic [15:0] a16, b16;
    logic [31:0] r16;

    multiplier_iterative_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .valid_in(v32), .ready_in(rdy_in32),
        .a(a32), .b(b32), .signed_in(s32), .valid_out(vo32), .ready_out(ro32), .r(r32)
    );

    multiplier_iterative_param #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .valid_in(v16), .ready_in(rdy_in16),
        .a(a16), .b(b16), .signed_in(s16), .valid_out(vo16), .ready_out(ro16), .r(r16)
    );

    typedef struct {
        logic [63:0] exp;
        int          acc_cyc;
    } item_t;

    item_t q32[$];
    item_t q16[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    bit    bp_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint p;
        if (s) p = longint'($signed(x)) * longint'($signed(y));
        else   p = longint'({32'b0, x}) * longint'({32'b0, y});
        return p;
    endfunction

    function automatic logic [63:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic s);
        int p;
        if (s) p = int'($signed(x)) * int'($signed(y));
        else   p = int'({16'b0, x}) * int'({16'b0, y});
        return {32'b0, p};
    endfunction

    // Monitor for the 32-bit instance: checks latency, result, hold under backpressure.
    initial begin
        bit seen;
        int stall;
        seen  = 0;
        stall = 0;
        ro32  = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen  = 0;
                stall = 0;
                ro32  = 1'b1;
            end else if (vo32) begin
                if (q32.size() == 0) begin
                    chk("valid_out32_unexpected", 64'(vo32), 64'(0));
                    ro32 = 1'b1;
                end else begin
                    if (!seen) begin
                        chk("latency32", 64'(cyc - q32[0].acc_cyc), 64'(32));
                        seen = 1;
                        if (bp_req) begin
                            stall  = 10;
                            bp_req = 0;
                        end
                    end
                    chk("r32", r32, q32[0].exp);
                    if (stall > 0) begin
                        ro32 = 1'b0;
                        stall--;
                    end else begin
                        ro32 = 1'b1;
                    end
                    #1;
                    chk("ready_in32_done", 64'(rdy_in32), 64'(ro32));
                    if (ro32) begin
                        void'(q32.pop_front());
                        seen = 0;
                    end
                end
            end else begin
                ro32 = 1'b1;
            end
        end
    end

    // Monitor for the 16-bit instance, with random consumer stalls.
    initial begin
        bit seen;
        seen = 0;
        ro16 = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
                ro16 = 1'b1;
            end else if (vo16) begin
                if (q16.size() == 0) begin
                    chk("valid_out16_unexpected", 64'(vo16), 64'(0));
                    ro16 = 1'b1;
                end else begin
                    if (!seen) begin
                        chk("latency16", 64'(cyc - q16[0].acc_cyc), 64'(4));
                        seen = 1;
                    end
                    chk("r16", {32'b0, r16}, q16[0].exp);
                    ro16 = ($urandom_range(0, 3) != 0);
                    #1;
                    chk("ready_in16_done", 64'(rdy_in16), 64'(ro16));
                    if (ro16) begin
                        void'(q16.pop_front());
                        seen = 0;
                    end
                end
            end else begin
                ro16 = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic issue32(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                           input logic [63:0] exp, input bit scramble);
        int w;
        w = 0;
        @(negedge clk);
        v32 = 1'b1; a32 = av; b32 = bv; s32 = sv;
        #1;
        while (!rdy_in32 && w < 300) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!rdy_in32) begin
            chk("accept_timeout32", 64'(rdy_in32), 64'(1));
            v32 = 1'b0;
        end else begin
            q32.push_back('{exp, cyc + 1});
            @(posedge clk);
            if (scramble) begin
                repeat (31) begin
                    @(negedge clk);
                    v32 = 1'($urandom_range(0, 1));
                    a32 = $urandom; b32 = $urandom;
                    s32 = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                v32 = 1'b0;
            end
        end
    endtask

    task automatic issue16(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                           input logic [63:0] exp);
        int w;
        w = 0;
        @(negedge clk);
        v16 = 1'b1; a16 = av; b16 = bv; s16 = sv;
        #1;
        while (!rdy_in16 && w < 300) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!rdy_in16) begin
            chk("accept_timeout16", 64'(rdy_in16), 64'(1));
            v16 = 1'b0;
        end else begin
            q16.push_back('{exp, cyc + 1});
            @(posedge clk);
        end
    endtask

    task automatic drain32();
        int w;
        w = 0;
        @(negedge clk);
        v32 = 1'b0;
        while (q32.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("drain32_pending", 64'(q32.size()), 64'(0));
    endtask

    task automatic drain16();
        int w;
        w = 0;
        @(negedge clk);
        v16 = 1'b0;
        while (q16.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("drain16_pending", 64'(q16.size()), 64'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] xa, xb;
        logic [15:0] ya, yb;
        logic        xs;

        rst_n = 1'b0;
        v32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0;
        v16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid_out32", 64'(vo32), 64'(0));
        chk("rst_r32", r32, 64'h0);
        chk("rst_ready_in32", 64'(rdy_in32), 64'(1));
        chk("rst_r16", {32'b0, r16}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            xa = 32'(i);
            issue32(xa, xa, 1'b0, 64'(i * i), 0);
        end

        xa = '0; xb = '0;
        for (int i = 0; i < 100; i++) begin
            issue32(xa, xb, 1'b0, ref32(xa, xb, 1'b0), 0);
            xa = xa + 32'h23456789;
            xb = xb + 32'h34567891;
        end

        issue32(32'hFFFFFFFD, 32'd5,        1'b1, 64'hFFFFFFFFFFFFFFF1, 0);
        issue32(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 0);
        issue32(32'h80000000, 32'd1,        1'b1, 64'hFFFFFFFF80000000, 0);
        issue32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 0);
        issue32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 0);
        issue32(32'hFFFFFFFF, 32'd0,        1'b1, 64'h0, 0);
        drain32();

        bp_req = 1;
        issue32(32'h12345678, 32'h9ABCDEF0, 1'b1, ref32(32'h12345678, 32'h9ABCDEF0, 1'b1), 0);
        issue32(32'hCAFEBABE, 32'h0000BEEF, 1'b0, ref32(32'hCAFEBABE, 32'h0000BEEF, 1'b0), 0);
        drain32();

        for (int i = 0; i < 20; i++) begin
            xa = $urandom; xb = $urandom; xs = 1'($urandom_range(0, 1));
            issue32(xa, xb, xs, ref32(xa, xb, xs), 1);
        end
        drain32();

        issue32(32'h76543210, 32'h0F0F0F0F, 1'b0, ref32(32'h76543210, 32'h0F0F0F0F, 1'b0), 0);
        @(negedge clk);
        v32 = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_valid_out32", 64'(vo32), 64'(0));
        chk("midrun_rst_r32", r32, 64'h0);
        chk("midrun_rst_ready_in32", 64'(rdy_in32), 64'(1));
        q32.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("aborted_op_no_valid32", 64'(vo32), 64'(0));
        chk("aborted_op_r32_zero", r32, 64'h0);

        issue16(16'h8000, 16'h8000, 1'b1, 64'h40000000);
        issue16(16'hFFFF, 16'hFFFF, 1'b0, 64'hFFFE0001);
        for (int i = 0; i < 50; i++) begin
            ya = 16'($urandom); yb = 16'($urandom); xs = 1'($urandom_range(0, 1));
            issue16(ya, yb, xs, ref16(ya, yb, xs));
        end
        drain16();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
